spi_burst_seq: RTL and testbench

Multi-byte SPI transaction sequencer. It sits directly upstream of the `spi_master` byte engine. It owns chip-select, with programmable setup, hold and inter-transfer gap. It feeds the engine one byte at a time over the engine's `tx_dv`/`tx_ready` handshake and returns each received MISO byte with its position in the burst.

---
 rtl/spi_burst_seq_pkg.sv | 27 ++
 rtl/spi_burst_seq_if.sv | 51 +++++
 rtl/spi_burst_seq_gap_cnt.sv | 43 ++++
 rtl/spi_burst_seq.sv | 212 +++++++++++++++++++++
 tb/tb_spi_burst_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_burst_seq_pkg.sv
// ============================================================================
// Module      : spi_seq_pkg
// Description : Shared state encoding and width helper for spi_burst_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_HOLD    = 3'd5,
    ST_GAP     = 3'd6
  } spi_seq_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int seq_len_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_burst_seq_if.sv
// ============================================================================
// Module      : spi_burst_seq_if
// Description : Upstream, engine and status signals of spi_burst_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_burst_seq_if
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES = 4
);
  localparam int LEN_W = seq_len_w(MAX_BYTES);

  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_tx_valid;
  logic [7:0]       i_tx_byte;
  logic             o_tx_ready;
  logic [7:0]       o_eng_tx_byte;
  logic             o_eng_tx_dv;
  logic             i_eng_tx_ready;
  logic             i_eng_rx_dv;
  logic [7:0]       i_eng_rx_byte;
  logic             o_rx_valid;
  logic [7:0]       o_rx_byte;
  logic [LEN_W-1:0] o_rx_index;
  logic             o_spi_cs_n;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  modport slave (
    input  i_start, i_len, i_tx_valid, i_tx_byte,
    input  i_eng_tx_ready, i_eng_rx_dv, i_eng_rx_byte,
    output o_tx_ready, o_eng_tx_byte, o_eng_tx_dv,
    output o_rx_valid, o_rx_byte, o_rx_index,
    output o_spi_cs_n, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_len, i_tx_valid, i_tx_byte,
    output i_eng_tx_ready, i_eng_rx_dv, i_eng_rx_byte,
    input  o_tx_ready, o_eng_tx_byte, o_eng_tx_dv,
    input  o_rx_valid, o_rx_byte, o_rx_index,
    input  o_spi_cs_n, o_busy, o_done, o_err
  );

endinterface

`default_nettype wire

// File: rtl/spi_burst_seq_gap_cnt.sv
// ============================================================================
// Module      : spi_seq_gap_cnt
// Description : Loadable down-counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_seq_gap_cnt #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  output logic                  o_zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_burst_seq.sv
// ============================================================================
// Module      : spi_burst_seq
// Description : Multi-byte SPI burst sequencer owning chip-select timing.
//               Optional RX watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_burst_seq
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES     = 4,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_IDLE_CLKS  = 4,
  parameter int TIMEOUT_CLKS  = 1024
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  spi_burst_seq_if.slave bus
);

  localparam int LEN_W   = seq_len_w(MAX_BYTES);
  localparam int GAP_MAX = (CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS;
  localparam int GAP_W   = seq_len_w(GAP_MAX);

  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES);
  localparam logic [GAP_W-1:0] SETUP_LOAD = GAP_W'(CS_SETUP_CLKS - 1);
  localparam logic [GAP_W-1:0] IDLE_LOAD  = GAP_W'(CS_IDLE_CLKS - 1);

  spi_seq_state_t   state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       eng_tx_byte_q, eng_tx_byte_d;
  logic             eng_tx_dv_q, eng_tx_dv_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [LEN_W-1:0] rx_index_q, rx_index_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             gap_load;
  logic [GAP_W-1:0] gap_load_val;
  logic             gap_en;
  logic             gap_zero;
  logic             wd_timeout;
  logic             tx_hs;
  logic [LEN_W-1:0] last_idx;

  assign tx_hs    = (state_q == ST_LOAD) && bus.i_tx_valid && bus.i_eng_tx_ready;
  assign last_idx = len_q - LEN_W'(1);
  assign gap_en   = (state_q == ST_SETUP) || (state_q == ST_HOLD) || (state_q == ST_GAP);

  spi_seq_gap_cnt #(
    .WIDTH (GAP_W)
  ) u_gap_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (gap_load),
    .i_load_val (gap_load_val),
    .i_en       (gap_en),
    .o_zero     (gap_zero)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = seq_len_w(TIMEOUT_CLKS);

  logic wd_zero;

  // Armed while the byte is launched so WAIT_RX gets exactly TIMEOUT_CLKS cycles.
  spi_seq_gap_cnt #(
    .WIDTH (WD_W)
  ) u_wd_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     ((state_q == ST_SEND) || bus.i_eng_rx_dv),
    .i_load_val (WD_W'(TIMEOUT_CLKS - 1)),
    .i_en       (state_q == ST_WAIT_RX),
    .o_zero     (wd_zero)
  );

  assign wd_timeout = (state_q == ST_WAIT_RX) && wd_zero;
`else
  assign wd_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    eng_tx_byte_d = eng_tx_byte_q;
    eng_tx_dv_d   = 1'b0;
    rx_valid_d    = 1'b0;
    rx_byte_d     = rx_byte_q;
    rx_index_d    = rx_index_q;
    cs_n_d        = cs_n_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    gap_load      = 1'b0;
    gap_load_val  = SETUP_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && (bus.i_len != '0)) begin
          len_d    = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
          idx_d    = '0;
          cs_n_d   = 1'b0;
          gap_load = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (gap_zero) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (tx_hs) begin
          eng_tx_byte_d = bus.i_tx_byte;
          eng_tx_dv_d   = 1'b1;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (bus.i_eng_rx_dv) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = bus.i_eng_rx_byte;
          rx_index_d = idx_q;
          if (idx_q == last_idx) begin
            gap_load = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = ST_LOAD;
          end
        end else if (wd_timeout) begin
          err_d    = 1'b1;
          gap_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (gap_zero) begin
          cs_n_d       = 1'b1;
          gap_load     = 1'b1;
          gap_load_val = IDLE_LOAD;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      eng_tx_byte_q <= '0;
      eng_tx_dv_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_byte_q     <= '0;
      rx_index_q    <= '0;
      cs_n_q        <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      eng_tx_byte_q <= eng_tx_byte_d;
      eng_tx_dv_q   <= eng_tx_dv_d;
      rx_valid_q    <= rx_valid_d;
      rx_byte_q     <= rx_byte_d;
      rx_index_q    <= rx_index_d;
      cs_n_q        <= cs_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.o_tx_ready    = tx_hs;
  assign bus.o_eng_tx_byte = eng_tx_byte_q;
  assign bus.o_eng_tx_dv   = eng_tx_dv_q;
  assign bus.o_rx_valid    = rx_valid_q;
  assign bus.o_rx_byte     = rx_byte_q;
  assign bus.o_rx_index    = rx_index_q;
  assign bus.o_spi_cs_n    = cs_n_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_seq.sv
// ============================================================================
// Module      : tb_spi_burst_seq
// Description : Self-checking bench for spi_burst_seq with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_burst_seq;
  import spi_seq_pkg::*;

  localparam int MAX_BYTES = 4;
  localparam int S_CLKS    = 2;
  localparam int I_CLKS    = 4;
  localparam int TMO_CLKS  = 1024;
  localparam int LEN_W     = seq_len_w(MAX_BYTES);

  typedef struct {
    int         len;
    int         exp_n;
    int         stall;
    int         lat;
    logic [7:0] xr;
    bit         restart;
    logic [31:0] bytes;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int         eng_lat = 0;
  int         eng_cnt = 0;
  bit         eng_busy = 1'b0;
  bit         eng_mute = 1'b0;
  logic [7:0] eng_xor = 8'h00;
  logic [7:0] eng_data = 8'h00;

  spi_burst_seq_if #(.MAX_BYTES(MAX_BYTES)) bus ();

  spi_burst_seq #(
    .MAX_BYTES     (MAX_BYTES),
    .CS_SETUP_CLKS (S_CLKS),
    .CS_IDLE_CLKS  (I_CLKS),
    .TIMEOUT_CLKS  (TMO_CLKS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: answers each tx strobe after eng_lat idle cycles with tx ^ eng_xor.
  always @(negedge clk) begin
    bus.i_eng_rx_dv = 1'b0;
    if (!reset_n) begin
      eng_busy = 1'b0;
    end else begin
      if (eng_busy) begin
        if (eng_cnt == 0) begin
          eng_busy = 1'b0;
          if (!eng_mute) begin
            bus.i_eng_rx_dv   = 1'b1;
            bus.i_eng_rx_byte = eng_data;
          end
        end else begin
          eng_cnt = eng_cnt - 1;
        end
      end
      if (bus.o_eng_tx_dv) begin
        eng_busy = 1'b1;
        eng_cnt  = eng_lat;
        eng_data = bus.o_eng_tx_byte ^ eng_xor;
      end
    end
    bus.i_eng_tx_ready = !eng_busy;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Drives one burst and compares every observed event with cycle-exact timing
  // derived from the sequencer's published latencies.
  task automatic run_burst(input vec_t v);
    int t0, l0, step, budget, k, n_tx, n_fall, n_rise, n_err, fall_c, rise_c, done_c, busy_hi, last_r;
    int q_tc[$];
    int q_rc[$];
    int q_rb[$];
    int q_ri[$];
    logic cs_prev;
    bit   fin;
    logic [7:0] b;
    eng_lat = v.lat;
    eng_xor = v.xr;
    @(negedge clk);
    t0 = cyc;
    bus.i_start = 1'b1;
    bus.i_len = LEN_W'(v.len);
    bus.i_tx_valid = 1'b0;
    k = 0; n_tx = 0; n_fall = 0; n_rise = 0; n_err = 0; busy_hi = 0;
    fall_c = -1; rise_c = -1; done_c = -1; fin = 1'b0;
    cs_prev = bus.o_spi_cs_n;
    budget = (v.exp_n == 0) ? 30 : v.exp_n * (3 + v.lat) + v.stall + 40;
    for (int n = 0; n < budget && !fin; n++) begin
      @(negedge clk);
      bus.i_start = v.restart && (cyc == t0 + 6);
      bus.i_len   = bus.i_start ? LEN_W'(1) : LEN_W'(v.len);
      if (bus.o_busy) busy_hi++;
      if (cs_prev && !bus.o_spi_cs_n) begin n_fall++; fall_c = cyc; end
      if (!cs_prev && bus.o_spi_cs_n) begin n_rise++; rise_c = cyc; end
      cs_prev = bus.o_spi_cs_n;
      if (bus.o_eng_tx_dv) begin
        b = v.bytes[8*(k%4) +: 8];
        chk("eng_tx_byte", int'(bus.o_eng_tx_byte), int'(b));
        q_tc.push_back(cyc);
        n_tx++;
        k++;
      end
      if (bus.o_rx_valid) begin
        q_rc.push_back(cyc);
        q_rb.push_back(int'(bus.o_rx_byte));
        q_ri.push_back(int'(bus.o_rx_index));
      end
      if (bus.o_err) n_err++;
      if (bus.o_done) begin done_c = cyc; fin = 1'b1; end
      bus.i_tx_valid = (k < 8) && (cyc >= t0 + 1 + S_CLKS + v.stall);
      bus.i_tx_byte  = v.bytes[8*(k%4) +: 8];
    end
    bus.i_tx_valid = 1'b0;
    bus.i_start    = 1'b0;

    if (v.exp_n == 0) begin
      chk("ignored_cs_fall", n_fall, 0);
      chk("ignored_busy", busy_hi, 0);
      chk("ignored_done", done_c, -1);
    end else begin
      l0   = t0 + 1 + S_CLKS + v.stall;
      step = 3 + v.lat;
      chk("tx_dv_count", n_tx, v.exp_n);
      chk("rx_valid_count", q_rc.size(), v.exp_n);
      chk("cs_fall_count", n_fall, 1);
      chk("cs_rise_count", n_rise, 1);
      chk("cs_fall_cycle", fall_c, t0 + 1);
      chk("err_count", n_err, 0);
      for (int i = 0; i < v.exp_n; i++) begin
        if (i < q_tc.size()) chk("tx_dv_cycle", q_tc[i], l0 + i * step + 1);
        if (i < q_rc.size()) begin
          chk("rx_cycle", q_rc[i], l0 + i * step + 3 + v.lat);
          chk("rx_byte", q_rb[i], int'(v.bytes[8*i +: 8] ^ v.xr));
          chk("rx_index", q_ri[i], i);
        end
      end
      last_r = l0 + (v.exp_n - 1) * step + 2 + v.lat;
      chk("cs_rise_cycle", rise_c, last_r + 1 + S_CLKS);
      chk("done_cycle", done_c, last_r + 1 + S_CLKS + I_CLKS);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    bit   seen;
    int   s_c, e_c, r_c, d_c;

    reset_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_len = '0;
    bus.i_tx_valid = 1'b0;
    bus.i_tx_byte = 8'h00;
    bus.i_eng_rx_byte = 8'h00;

    vecs[0] = '{len: 1, exp_n: 1, stall: 0,  lat: 0, xr: 8'h00, restart: 1'b0, bytes: 32'h0000_00A5};
    vecs[1] = '{len: 4, exp_n: 4, stall: 0,  lat: 1, xr: 8'h00, restart: 1'b1, bytes: 32'h0403_0201};
    vecs[2] = '{len: 7, exp_n: 4, stall: 0,  lat: 2, xr: 8'h5A, restart: 1'b0, bytes: 32'hDEAD_BEEF};
    vecs[3] = '{len: 0, exp_n: 0, stall: 0,  lat: 0, xr: 8'h00, restart: 1'b0, bytes: 32'h0000_0000};
    vecs[4] = '{len: 4, exp_n: 4, stall: 50, lat: 0, xr: 8'h00, restart: 1'b0, bytes: 32'h4433_2211};
    vecs[5] = '{len: 3, exp_n: 3, stall: 0,  lat: 4, xr: 8'hFF, restart: 1'b0, bytes: 32'h00C3_3C81};

    repeat (3) @(negedge clk);
    chk("reset_cs_n", int'(bus.o_spi_cs_n), 1);
    chk("reset_busy", int'(bus.o_busy), 0);
    chk("reset_done", int'(bus.o_done), 0);
    chk("reset_err", int'(bus.o_err), 0);
    chk("reset_rx_valid", int'(bus.o_rx_valid), 0);
    chk("reset_tx_dv", int'(bus.o_eng_tx_dv), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      rv.len     = int'($urandom_range(1, 7));
      rv.exp_n   = (rv.len > MAX_BYTES) ? MAX_BYTES : rv.len;
      rv.stall   = int'($urandom_range(0, 6));
      rv.lat     = int'($urandom_range(0, 4));
      rv.xr      = 8'($urandom);
      rv.restart = 1'($urandom);
      rv.bytes   = $urandom;
      run_burst(rv);
    end

    // Asynchronous reset while waiting for the engine's answer.
    eng_lat = 6;
    eng_xor = 8'h00;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len = LEN_W'(4);
    bus.i_tx_valid = 1'b1;
    bus.i_tx_byte = 8'h11;
    @(negedge clk);
    bus.i_start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.o_eng_tx_dv) seen = 1'b1;
    end
    chk("rst_pre_tx_dv_seen", int'(seen), 1);
    bus.i_tx_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_cs_low", int'(bus.o_spi_cs_n), 0);
    chk("rst_pre_busy", int'(bus.o_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_cs_high", int'(bus.o_spi_cs_n), 1);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_err", int'(bus.o_err), 0);
    chk("rst_rx_valid", int'(bus.o_rx_valid), 0);
    chk("rst_rx_byte", int'(bus.o_rx_byte), 0);
    chk("rst_rx_index", int'(bus.o_rx_index), 0);
    chk("rst_eng_tx_byte", int'(bus.o_eng_tx_byte), 0);
    chk("rst_tx_ready", int'(bus.o_tx_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_burst(vecs[1]);

`ifdef SPI_SEQ_TIMEOUT_EN
    eng_mute = 1'b1;
    eng_lat = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len = LEN_W'(1);
    bus.i_tx_valid = 1'b1;
    bus.i_tx_byte = 8'h3C;
    s_c = -1; e_c = -1; r_c = -1; d_c = -1;
    for (int n = 0; n < TMO_CLKS + 40 && d_c < 0; n++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_eng_tx_dv) begin s_c = cyc; bus.i_tx_valid = 1'b0; end
      if (bus.o_err) e_c = cyc;
      if (bus.o_spi_cs_n && r_c < 0 && s_c >= 0) r_c = cyc;
      if (bus.o_done) d_c = cyc;
    end
    chk("wd_tx_dv_seen", int'(s_c >= 0), 1);
    chk("wd_err_cycle", e_c, s_c + 1 + TMO_CLKS);
    chk("wd_cs_rise_cycle", r_c, e_c + S_CLKS);
    chk("wd_done_cycle", d_c, r_c + I_CLKS);
    eng_mute = 1'b0;
`else
    s_c = 0; e_c = 0; r_c = 0; d_c = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
